regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 135 +++++++++++++
 tb/tb_regfile_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port and register dump stream.
// master drives requests (testbench/CPU side), slave is the register file.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   dump_start;
    logic                   dump_valid;
    logic                   dump_ready;
    logic [ADDR_W-1:0]      dump_addr;
    logic [DATA_W-1:0]      dump_data;
    logic                   dump_busy;
    logic                   dump_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
        input  rd_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
        output rd_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/regfile_param.sv
// Parameterised register file with N_RD combinational read ports, one write port and a
// ready/valid register dump engine. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int N_RD    = 2,
    parameter int SP_IDX  = 29,
    parameter     SP_INIT = 32'h7fffffff
) (
    input  logic          clock_debug,
    input  logic          reset,
    regfile_param_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DATA_W-1:0]      regs_s [DEPTH];
    logic [N_RD*DATA_W-1:0] rd_data_s;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [ADDR_W-1:0]      ptr_r;
    logic [ADDR_W-1:0]      ptr_nxt_s;
    logic                   valid_r;
    logic                   busy_r;
    logic                   done_r;

    // Register 0 is hard-wired to zero; SP_IDX = 0 therefore never takes effect.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign regs_s[i] = {DATA_W{1'b0}};
        end else begin : g_store
            logic [DATA_W-1:0] q_r;

            // Storage element: async reset to its power-on value, write on address match.
            always_ff @(posedge clock_debug or posedge reset) begin
                if (reset) begin
                    q_r <= (i == SP_IDX) ? SP_VAL : {DATA_W{1'b0}};
                end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
                    q_r <= bus.wr_data;
                end else begin
                    q_r <= q_r;
                end
            end

            assign regs_s[i] = q_r;
        end
    end

    // Combinational read ports, optionally forwarding the in-flight write.
    always_comb begin
        rd_data_s = {(N_RD*DATA_W){1'b0}};
        for (int k = 0; k < N_RD; k++) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && (bus.wr_addr != {ADDR_W{1'b0}}) &&
                (bus.wr_addr == bus.rd_addr[k*ADDR_W +: ADDR_W])) begin
                rd_data_s[k*DATA_W +: DATA_W] = bus.wr_data;
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = regs_s[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            end
`else
            rd_data_s[k*DATA_W +: DATA_W] = regs_s[bus.rd_addr[k*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign bus.rd_data = rd_data_s;

    // Dump sequencer next-state: the pointer is parked at zero outside DUMP so dump_addr idles at 0.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                ptr_nxt_s = {ADDR_W{1'b0}};
                if (bus.dump_start) begin
                    state_nxt_s = ST_DUMP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (bus.dump_ready) begin
                    if (ptr_r == PTR_LAST) begin
                        state_nxt_s = ST_DONE;
                        ptr_nxt_s   = {ADDR_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_DUMP;
                        ptr_nxt_s   = ptr_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_DUMP;
                    ptr_nxt_s   = ptr_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = {ADDR_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Dump state, pointer and status flags, all registered from the next state.
    always_ff @(posedge clock_debug or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            valid_r <= (state_nxt_s == ST_DUMP);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.dump_valid = valid_r;
    assign bus.dump_busy  = busy_r;
    assign bus.dump_done  = done_r;
    assign bus.dump_addr  = ptr_r;
    // Dump data is read live so a stalled beat tracks writes to its register.
    assign bus.dump_data  = valid_r ? regs_s[ptr_r] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_regfile_param.sv
// Randomised scoreboard bench for regfile_param: a driver pushes expectations computed from an
// array model, and a negedge monitor pops and compares read data and the dump stream.
module tb_regfile_param;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SP     = 29;

    logic clock_debug = 1'b0;
    logic reset;

    regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) bus ();

    regfile_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .SP_IDX(SP), .SP_INIT(32'h7fffffff)
    ) dut (
        .clock_debug(clock_debug),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock_debug = ~clock_debug;

    logic [DATA_W-1:0]      model [DEPTH];
    logic [N_RD*DATA_W-1:0] rd_q [$];
    logic [ADDR_W-1:0]      dump_q [$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  dumps_issued = 0;
    int  dumps_started = 0;
    logic              pend_we = 1'b0;
    logic [ADDR_W-1:0] pend_wa = '0;
    logic [DATA_W-1:0] pend_wd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model[SP] = 32'h7fffffff;
    endtask

    // Expected read data for the inputs currently on the bus.
    task automatic push_reads();
        logic [N_RD*DATA_W-1:0] e;
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < N_RD; k++) begin
            a = bus.rd_addr[k*ADDR_W +: ADDR_W];
            e[k*DATA_W +: DATA_W] = model[a];
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a) e[k*DATA_W +: DATA_W] = bus.wr_data;
`endif
        end
        rd_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock_debug);
        #1;
        if (pend_we && pend_wa != 0) model[pend_wa] = pend_wd;
        pend_we = 1'b0;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic ds, input logic dr,
                         input logic [N_RD*ADDR_W-1:0] ra);
        tick();
        reset = rst;
        if (rst) begin
            model_reset();
            dump_q.delete();
        end
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.dump_start = ds; bus.dump_ready = dr; bus.rd_addr = ra;
        pend_we = we && !rst; pend_wa = wa; pend_wd = wd;
        push_reads();
    endtask

    function automatic logic [N_RD*ADDR_W-1:0] rand_ra();
        logic [N_RD*ADDR_W-1:0] r;
        for (int k = 0; k < N_RD; k++) r[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH-1));
        return r;
    endfunction

    task automatic idle_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rand_ra());
    endtask

    // mode 0: ready always high; 1: ready toggles, stalled register rewritten; 2: random.
    task automatic run_dump(input int mode);
        int cnt;
        logic dr, we, ds;
        logic [ADDR_W-1:0] wa;
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, rand_ra());
        for (int a = 0; a < DEPTH; a++) dump_q.push_back(ADDR_W'(a));
        dumps_issued++;
        cnt = 0;
        while (dump_q.size() > 0 && cnt < 8*DEPTH) begin
            ds = ($urandom_range(0, 3) == 0);
            wa = ADDR_W'($urandom_range(0, DEPTH-1));
            we = ($urandom_range(0, 2) == 0);
            case (mode)
                0: dr = 1'b1;
                1: begin
                    dr = cnt[0];
                    if (!dr && dump_q.size() > 0) begin we = 1'b1; wa = dump_q[0]; end
                end
                default: begin
                    dr = ($urandom_range(0, 1) == 1);
                    if (dump_q.size() > 0 && $urandom_range(0, 3) == 0) wa = dump_q[0];
                end
            endcase
            drive(1'b0, we, wa, $urandom, ds, dr, rand_ra());
            cnt++;
        end
        check("dump_drained", 64'(dump_q.size()), 64'd0);
        idle_cycle();
        idle_cycle();
    endtask

    // Monitor: compares read ports every cycle and tracks the dump stream.
    initial begin : monitor
        int phase;
        logic [N_RD*DATA_W-1:0] exp;
        logic [ADDR_W-1:0] ea;
        phase = 0;
        forever begin
            @(negedge clock_debug);
            if (rd_q.size() > 0) begin
                exp = rd_q.pop_front();
                check("rd_data", 64'(bus.rd_data), 64'(exp));
            end
            if (reset) begin
                phase = 0;
                check("reset_flags", {61'd0, bus.dump_valid, bus.dump_busy, bus.dump_done}, 64'd0);
            end else begin
                case (phase)
                    0: begin
                        check("idle_outputs", {bus.dump_valid, bus.dump_busy, bus.dump_done,
                              bus.dump_addr, bus.dump_data}, 64'd0);
                        if (dumps_issued > dumps_started) begin
                            dumps_started++;
                            phase = 1;
                        end
                    end
                    1: begin
                        check("dump_flags", {61'd0, bus.dump_valid, bus.dump_busy, bus.dump_done}, 64'b110);
                        if (dump_q.size() == 0) begin
                            check("dump_extra_beat", 64'(bus.dump_addr), 64'hFFFF);
                            phase = 0;
                        end else begin
                            ea = dump_q[0];
                            check("dump_addr", 64'(bus.dump_addr), 64'(ea));
                            if (bus.dump_ready) begin
                                check("dump_data", 64'(bus.dump_data), 64'(model[ea]));
                                void'(dump_q.pop_front());
                                if (dump_q.size() == 0) phase = 2;
                            end
                        end
                    end
                    default: begin
                        check("done_flags", {61'd0, bus.dump_valid, bus.dump_busy, bus.dump_done}, 64'b011);
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin : driver
        logic [N_RD*ADDR_W-1:0] ra;
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.dump_start = 1'b0; bus.dump_ready = 1'b0; bus.rd_addr = '0;
        model_reset();
        // Writes attempted under reset must be dropped.
        drive(1'b1, 1'b1, 5'd5, 32'hBAD0BAD0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 5'd29, 32'h0BADF00D, 1'b0, 1'b0, '0);
        idle_cycle();
        for (int a = 0; a < DEPTH; a++) begin
            ra = {ADDR_W'(DEPTH-1-a), ADDR_W'(a)};
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ra);
        end
        check("sp_reset_model", 64'(model[SP]), 64'h7fffffff);
        drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, {5'd0, 5'd0});
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, {5'd0, 5'd5});
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, {5'd5, 5'd0});
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, {5'd5, 5'd5});
        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b0, {5'd7, 5'd0});
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, {5'd7, 5'd7});
        for (int i = 0; i < 200; i++)
            drive(1'b0, ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, DEPTH-1)),
                  $urandom, 1'b0, 1'b0, rand_ra());
        run_dump(0);
        run_dump(1);
        // Reset in the middle of a dump, with the pointer sitting at 10.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, rand_ra());
        for (int a = 0; a < DEPTH; a++) dump_q.push_back(ADDR_W'(a));
        dumps_issued++;
        for (int i = 0; i < 4*DEPTH && dump_q.size() > DEPTH-10; i++)
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rand_ra());
        check("dump_ptr_before_reset", 64'(bus.dump_addr), 64'd10);
        reset = 1'b1;
        model_reset();
        dump_q.delete();
        pend_we = 1'b0;
        void'(rd_q.pop_back());
        push_reads();
        #1;
        check("reset_mid_dump", {62'd0, bus.dump_valid, bus.dump_busy}, 64'd0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, rand_ra());
        idle_cycle();
        run_dump(0);
        for (int i = 0; i < 4; i++) run_dump(2);
        idle_cycle();
        tick();
        @(negedge clock_debug);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
